rle_symbol_serializer: RTL
==========================

// Module: rle_symbol_serializer
// PURPOSE
//  Downstream of the 8-lane run-length stage. Takes one group per handshake: 8 coefficients,
//  8 nonzero flags, 8 run fields. Emits one (run, value) symbol per cycle for nonzero lanes only,
//  lane 1 (in_coef[63:56]) first. Emits an EOB symbol at block end when the block's last coefficient is zero.
//  Output feeds the entropy coder.
// PARAMETERS
//  none (lane count 8, coef width 8, run width 4 are fixed by the upstream stage)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous reset, active low
//  in_valid   in   1   group present
//  in_ready   out  1   group accepted when in_valid & in_ready
//  in_coef    in   64  lane k value = in_coef[71-8k -: 8], k=1..8
//  in_en      in   8   in_en[8-k] = lane k nonzero flag (en1 is MSB)
//  in_run     in   32  lane k run = in_run[35-4k -: 4] (run1 in MSBs)
//  in_last    in   1   group is the 8th (final) group of a 64-coef block
//  sym_valid  out  1   symbol present
//  sym_ready  in   1   consumer accepts when sym_valid & sym_ready
//  sym_run    out  4   zero-run preceding the value
//  sym_val    out  8   coefficient value (0 for EOB)
//  sym_eob    out  1   symbol is End-Of-Block
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, mask=0, in_ready=1, sym_valid=0, sym_run=0, sym_val=0,
//    sym_eob=0. All holding registers are 0. Reset mid-block discards the held group and any EOB pending.
//  - Accept: registers coef, run, mask<=in_en, last<=in_last, eob_need<=in_last & ~in_en[0].
//  - States:
//    - IDLE: in_ready=1, sym_valid=0.
//      - Accept with in_en!=0 -> EMIT.
//      - Accept with in_en==0 and eob_need -> EOB.
//      - Accept with in_en==0 and ~in_last -> stay IDLE (zero group consumes 1 cycle).
//    - EMIT: sym_valid=1. Symbol = lowest-numbered set lane of mask; run/val from that lane; sym_eob=0.
//      - On handshake, clear that mask bit.
//      - If bits remain -> stay EMIT.
//      - Else if eob_need -> EOB.
//      - Else -> IDLE, with fast reload.
//    - EOB: sym_valid=1, sym_run=0, sym_val=0, sym_eob=1. On handshake -> IDLE.
//  - Fast reload: in_ready=1 also in EMIT when exactly one mask bit is set, sym_ready=1 and ~eob_need.
//    - A group accepted that cycle loads directly. Next state follows the IDLE-accept rules.
//    - Result: back-to-back groups with one nonzero each sustain 1 symbol/cycle.
//  - Latency: accept at edge N, first symbol valid after edge N (registered outputs, no comb in->out path).
//  - Stall: while sym_valid & ~sym_ready, sym_run/sym_val/sym_eob hold stable. in_ready=0 except in IDLE.
//  - in_* are sampled only on an accept. Values are passed unchanged (8-bit two's complement).
//  - Run fields are forwarded verbatim; 4-bit wrap of long runs is the upstream stage's responsibility.
//  - A last group with in_en[0]=1 emits no EOB. An all-zero block yields exactly one EOB symbol.
// CONFIGURATION
//  RLE_SER_SYMCNT_EN defined: adds ports
//    - blk_sym_cnt  out 7  symbols emitted in the block just finished, including EOB.
//    - blk_done     out 1  1-cycle pulse when the block's final symbol handshakes.
//  Counter rules:
//    - Counter clears on reset and after each blk_done.
//    - blk_sym_cnt holds its value until the next blk_done. Reset value 0.
//    - A block ending with in_last and no symbols pending pulses blk_done on the accept cycle.
//  Not defined: the ports and the counter are absent. All other behaviour is identical.
// TESTING
//  1. Reset mid-EMIT (3 bits pending, rst_n low 1 cycle) -> all outputs 0, in_ready=1, no stale symbol afterwards.
//  2. One group: in_en=8'b1010_0001, runs 0/2/3, in_last=0, sym_ready=1
//     -> symbols (0,v1), (2,v3), (3,v8) on 3 consecutive cycles, then IDLE, no EOB.
//  3. Eight groups: group1 en=8'h80, groups 2-8 en=0, last on group 8
//     -> one symbol, then after group 8 exactly one EOB (run=0, val=0, eob=1).
//  4. Last group en=8'h01, coef lane8=8'hF3, run=5 -> symbol (5, 8'hF3), sym_eob never asserted.
//  5. Backpressure: toggle sym_ready 1010... during en=8'hFF
//     -> 8 symbols in lane order, fields stable while stalled, none dropped or duplicated.
//  6. Fast reload: consecutive groups en=8'h10 each, sym_ready=1 -> 1 symbol/cycle, in_ready stays 1.
//     With RLE_SER_SYMCNT_EN, a block of 3 nonzeros plus EOB -> blk_sym_cnt=4.

Source files
------------

// File: rtl/rle_symbol_serializer.sv
// Serializes 8-lane run-length groups into one (run, value) symbol per cycle, lane 1 first,
// with an End-Of-Block symbol when a block ends on a zero coefficient. Optional RLE_SER_SYMCNT_EN adds a per-block symbol counter.
module rle_symbol_serializer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_coef,
    input  logic [7:0]  in_en,
    input  logic [31:0] in_run,
    input  logic        in_last,
    output logic        sym_valid,
    input  logic        sym_ready,
    output logic [3:0]  sym_run,
    output logic [7:0]  sym_val,
    output logic        sym_eob
`ifdef RLE_SER_SYMCNT_EN
    ,
    output logic [6:0]  blk_sym_cnt,
    output logic        blk_done
`endif
);

    typedef enum logic [1:0] {IDLE, EMIT, EOB} state_t;

    state_t          state;
    logic [7:0][7:0] coef_q;
    logic [7:0][3:0] run_q;
    logic [7:0]      mask_q;
    logic            eob_need_q;

    // Bit b of in_en pairs with coef byte b and run nibble b, so lane 1 is bit 7.
    logic [7:0][7:0] in_coef_lanes;
    logic [7:0][3:0] in_run_lanes;
    logic [2:0]      in_lane, cur_lane, next_lane;
    logic [7:0]      mask_next;
    logic            accept, sym_hs, single_bit;

    assign in_coef_lanes = in_coef;
    assign in_run_lanes  = in_run;

    // Highest set bit wins, which is the lowest-numbered lane.
    function automatic logic [2:0] top_lane(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (m[b]) idx = 3'(b);
        end
        return idx;
    endfunction

    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    always_comb begin
        in_lane    = top_lane(in_en);
        cur_lane   = top_lane(mask_q);
        mask_next  = mask_q & ~(8'b1 << cur_lane);
        next_lane  = top_lane(mask_next);
        single_bit = (mask_q != 8'd0) && (mask_next == 8'd0);
        in_ready   = (state == IDLE) ||
                     ((state == EMIT) && single_bit && sym_ready && !eob_need_q);
    end

    assign accept = in_valid & in_ready;
    assign sym_hs = sym_valid & sym_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    // NOTE: the holding registers are small flops, not a memory, so they reset with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            coef_q     <= '0;
            run_q      <= '0;
            mask_q     <= 8'd0;
            eob_need_q <= 1'b0;
            sym_valid  <= 1'b0;
            sym_run    <= 4'd0;
            sym_val    <= 8'd0;
            sym_eob    <= 1'b0;
        end else if (accept) begin
            // Covers both the IDLE accept and the fast reload out of EMIT.
            coef_q     <= in_coef_lanes;
            run_q      <= in_run_lanes;
            mask_q     <= in_en;
            eob_need_q <= in_last & ~in_en[0];
            if (in_en != 8'd0) begin
                state     <= EMIT;
                sym_valid <= 1'b1;
                sym_run   <= in_run_lanes[in_lane];
                sym_val   <= in_coef_lanes[in_lane];
                sym_eob   <= 1'b0;
            end else if (in_last) begin
                state     <= EOB;
                sym_valid <= 1'b1;
                sym_run   <= 4'd0;
                sym_val   <= 8'd0;
                sym_eob   <= 1'b1;
            end else begin
                state     <= IDLE;
                sym_valid <= 1'b0;
                sym_run   <= 4'd0;
                sym_val   <= 8'd0;
                sym_eob   <= 1'b0;
            end
        end else if (sym_hs) begin
            case (state)
                EMIT: begin
                    mask_q <= mask_next;
                    if (mask_next != 8'd0) begin
                        sym_run <= run_q[next_lane];
                        sym_val <= coef_q[next_lane];
                    end else if (eob_need_q) begin
                        state   <= EOB;
                        sym_run <= 4'd0;
                        sym_val <= 8'd0;
                        sym_eob <= 1'b1;
                    end else begin
                        state     <= IDLE;
                        sym_valid <= 1'b0;
                        sym_run   <= 4'd0;
                        sym_val   <= 8'd0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    eob_need_q <= 1'b0;
                    sym_valid  <= 1'b0;
                    sym_run    <= 4'd0;
                    sym_val    <= 8'd0;
                    sym_eob    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RLE_SER_SYMCNT_EN
    logic       last_q;
    logic [6:0] sym_cnt_q;
    logic       final_hs;

    // The block ends on its EOB, or on the last symbol of a final group that needs no EOB.
    assign final_hs = sym_hs & (sym_eob |
                      ((state == EMIT) && (mask_next == 8'd0) && last_q && !eob_need_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= 1'b0;
            sym_cnt_q   <= 7'd0;
            blk_sym_cnt <= 7'd0;
            blk_done    <= 1'b0;
        end else begin
            blk_done <= 1'b0;
            if (accept) last_q <= in_last;
            if (final_hs) begin
                blk_sym_cnt <= sym_cnt_q + 7'd1;
                sym_cnt_q   <= 7'd0;
                blk_done    <= 1'b1;
            end else if (sym_hs) begin
                sym_cnt_q <= sym_cnt_q + 7'd1;
            end
        end
    end
`endif

endmodule
